// File: rtl/pll_clk_div_pkg.sv
// Shared constants and types for the programmable LED-rate clock divider.
package pll_clk_div_pkg;

   localparam int CNT_W_DEF       = 26;
   localparam int DIV_DEFAULT_DEF = 25_000_000;
   localparam int LOCK_CYCLES_DEF = 4;

   typedef logic [CNT_W_DEF-1:0] hp_t;

   // Width of a counter that must be able to hold the value n.
   function automatic int cnt_w_for(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pll_lock_det.sv
// Lock qualifier: counts divided-clock rising edges since reset or since the
// last change of the latched half-period. Only built with PLL_CLK_DIV_LOCK_EN.
module pll_lock_det
   import pll_clk_div_pkg::*;
#(
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
)(
   input  logic clk,
   input  logic clr_n,
   input  logic en,
   input  logic tick,
   input  logic h_chg,
   output logic locked
);

   localparam int LW = cnt_w_for(LOCK_CYCLES);

   logic [LW-1:0] r_cnt;
   logic          r_locked;

   // A half-period change restarts qualification; the counter saturates once locked.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_cnt    <= {LW{1'b0}};
         r_locked <= 1'b0;
      end else if (en && h_chg) begin
         r_cnt    <= {LW{1'b0}};
         r_locked <= 1'b0;
      end else if (en && tick && !r_locked) begin
         r_cnt    <= r_cnt + LW'(1);
         r_locked <= (r_cnt == LW'(LOCK_CYCLES - 1));
      end else begin
         r_cnt    <= r_cnt;
         r_locked <= r_locked;
      end
   end

   assign locked = r_locked;

endmodule

// File: rtl/pll_clk_div.sv
// Programmable 50%-duty clock divider with rise strobe and lock indicator.
// Optional lock qualification is enabled by defining PLL_CLK_DIV_LOCK_EN.
module pll_clk_div
   import pll_clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
)(
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [CNT_W-1:0] half_period,
   output logic             clk_out,
   output logic             tick,
   output logic             locked
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_h_q;
   logic [CNT_W-1:0] w_h_eff;
   logic             r_clk_out;
   logic             r_tick;
   logic             w_tc;
   logic             w_rise;

   assign w_h_eff = (half_period == {CNT_W{1'b0}}) ? CNT_W'(DIV_DEFAULT) : half_period;
   assign w_tc    = (r_cnt == (r_h_q - CNT_W'(1)));
   assign w_rise  = en & w_tc & ~r_clk_out;

   // h_q is only reloaded at a terminal count so a phase never changes length midway.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_cnt     <= {CNT_W{1'b0}};
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_h_q     <= w_h_eff;
      end else if (en && w_tc) begin
         r_cnt     <= {CNT_W{1'b0}};
         r_clk_out <= ~r_clk_out;
         r_tick    <= w_rise;
         r_h_q     <= w_h_eff;
      end else if (en) begin
         r_cnt     <= r_cnt + CNT_W'(1);
         r_clk_out <= r_clk_out;
         r_tick    <= 1'b0;
         r_h_q     <= r_h_q;
      end else begin
         r_cnt     <= r_cnt;
         r_clk_out <= r_clk_out;
         r_tick    <= 1'b0;
         r_h_q     <= r_h_q;
      end
   end

   assign clk_out = r_clk_out;
   assign tick    = r_tick;

`ifdef PLL_CLK_DIV_LOCK_EN
   logic w_h_chg;

   assign w_h_chg = en & w_tc & (w_h_eff != r_h_q);

   pll_lock_det #(
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lock_det (
      .clk    (clk),
      .clr_n  (clr_n),
      .en     (en),
      .tick   (w_rise),
      .h_chg  (w_h_chg),
      .locked (locked)
   );
`else
   logic r_locked;

   // Without qualification the output is declared stable as soon as reset releases.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_locked <= 1'b0;
      end else begin
         r_locked <= 1'b1;
      end
   end

   assign locked = r_locked;
`endif

endmodule

// File: tb/tb_pll_clk_div.sv
// Directed self-checking bench for pll_clk_div (honours PLL_CLK_DIV_LOCK_EN).
module tb_pll_clk_div;

   localparam int CNT_W = 8;
   localparam int DIV_D = 5;
   localparam int LOCK  = 4;

   logic             clk = 1'b0;
   logic             clr_n = 1'b0;
   logic             en = 1'b1;
   logic [CNT_W-1:0] half_period = 8'd3;
   logic             clk_out;
   logic             tick;
   logic             locked;

   int n_run  = 0;
   int n_fail = 0;

   pll_clk_div #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_D),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .en          (en),
      .half_period (half_period),
      .clk_out     (clk_out),
      .tick        (tick),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   // k = enabled edges since reset release, h = half-period in force from release.
   function automatic logic exp_clk(input int h, input int k);
      return ((k / h) % 2) == 1;
   endfunction

   function automatic logic exp_tick(input int h, input int k);
      return (k >= h) && ((k % (2 * h)) == h);
   endfunction

   function automatic logic exp_lock(input int h, input int k);
`ifdef PLL_CLK_DIV_LOCK_EN
      int rises;
      rises = (k >= h) ? ((k - h) / (2 * h) + 1) : 0;
      return rises >= LOCK;
`else
      return (h > 0) || (k >= 0);
`endif
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic [CNT_W-1:0] hp, input string tag);
      half_period = hp;
      clr_n = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rst_clk"},  clk_out, 1'b0);
      chk({tag, "_rst_tick"}, tick,    1'b0);
      chk({tag, "_rst_lock"}, locked,  1'b0);
      clr_n = 1'b1;
   endtask

   task automatic run(input int h, input int ka, input int kb, input string tag);
      for (int k = ka; k <= kb; k++) begin
         @(posedge clk); #1;
         chk($sformatf("%s_clk_k%0d", tag, k),  clk_out, exp_clk(h, k));
         chk($sformatf("%s_tick_k%0d", tag, k), tick,    exp_tick(h, k));
         chk($sformatf("%s_lock_k%0d", tag, k), locked,  exp_lock(h, k));
      end
   endtask

   initial begin
      // Basic divide H=3: rises on edges 3, 9, 15, 21; the 4th rise qualifies lock.
      @(posedge clk); #1;
      do_reset(8'd3, "basic");
      run(3, 1, 21, "basic");

      // Reset while clk_out is high, then minimum half-period.
      chk("midrun_clk_high", clk_out, 1'b1);
      do_reset(8'd1, "hmin");
      run(1, 1, 8, "hmin");

      // half_period = 0 selects DIV_DEFAULT = 5.
      do_reset(8'd0, "dflt");
      run(5, 1, 20, "dflt");

      // Stall 4 cycles inside a high phase: phase stretches to 7 cycles.
      do_reset(8'd3, "stall");
      run(3, 1, 4, "stall");
      en = 1'b0;
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); #1;
         chk($sformatf("stall_hold_clk_s%0d", s),  clk_out, 1'b1);
         chk($sformatf("stall_hold_tick_s%0d", s), tick,    1'b0);
         chk($sformatf("stall_hold_lock_s%0d", s), locked,  exp_lock(3, 4));
      end
      en = 1'b1;
      run(3, 5, 13, "stall");

      // Live retune 3 -> 2 at cnt = 1 of the high phase starting on edge 21.
      do_reset(8'd3, "retune");
      run(3, 1, 22, "retune");
      half_period = 8'd2;
      run(3, 23, 23, "retune");
      run(2, 0, 15, "retune2");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_clk_div.md
# pll_clk_div

Programmable clock divider that produces the slow, visible-rate clock driving the LED shift register. It also produces a one-cycle rising-edge strobe in the source clock domain and a lock indicator. It is driven by the board clock and replaces a vendor PLL, so the rest of the datapath can run LED animations at human-visible rates.

## Interface
Parameters:
- CNT_W, 26: width of the half-period counter and of `half_period`.
- DIV_DEFAULT, 25_000_000: half-period in `clk` cycles, used when `half_period` is 0. This gives 1 Hz from 50 MHz.
- LOCK_CYCLES, 4: number of `clk_out` rising edges required before `locked` asserts.

Ports:
- clk, in, 1: board clock. This is the only clock in the block.
- clr_n, in, 1: reset. Synchronous and active-low, sampled on the `clk` rising edge.
- en, in, 1: count enable. When low, all state holds.
- half_period, in, CNT_W: requested half-period H in `clk` cycles. A value of 0 selects DIV_DEFAULT.
- clk_out, out, 1: divided clock. Period is 2·H, duty cycle is 50%, and it is registered.
- tick, out, 1: one-`clk` pulse, high in the first cycle of each `clk_out` high phase.
- locked, out, 1: high when the output frequency is stable.

## Operation
- **Effective half-period.** H_eff = (half_period == 0) ? DIV_DEFAULT : half_period.
  - H_eff is latched into h_q on reset and at every terminal count.
  - h_q never changes mid-half-period.
- **Counter.** cnt runs 0..h_q−1 and advances on each `clk` edge with en=1.
- **Terminal count.** When cnt == h_q−1 and en=1:
  - cnt ← 0;
  - clk_out toggles;
  - h_q ← H_eff.
- **Tick.** tick ← 1 on the edge where clk_out goes 0→1; otherwise tick ← 0.
- **en = 0.** cnt, clk_out and h_q hold, and tick ← 0. The current phase is stretched by the number of disabled cycles.
- **H = 1.** clk_out toggles every enabled cycle, giving clk/2. tick is high every other cycle.
- **Reset values.** When clr_n is low on a `clk` edge:
  - cnt = 0, clk_out = 0, tick = 0, locked = 0;
  - h_q = H_eff at that edge.
- **Reset mid-operation.** Reset overrides everything on the same edge.
- **Arithmetic.** Unsigned, CNT_W bits, with no wrap: cnt never exceeds h_q−1.

## Timing
- Reset release (first edge with clr_n = 1, en = 1) starts counting at cnt = 0.
- First clk_out rise happens on the H-th enabled edge after reset release. tick is high in that same cycle.
- Steady state:
  - clk_out high for exactly H enabled cycles, then low for H;
  - tick period is 2H enabled cycles.
- A change to half_period takes effect at the next terminal count, so it can take up to one half-period to apply.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
The feature is controlled by macro `PLL_CLK_DIV_LOCK_EN`.
- **Defined:**
  - locked rises on the LOCK_CYCLES-th clk_out rising edge after reset.
  - locked drops to 0 on the edge where a latched h_q differs from its previous value, then re-qualifies over LOCK_CYCLES new rising edges.
  - en = 0 holds the lock counter.
- **Undefined:** locked = 1 from the first edge with clr_n = 1 and stays 1 until the next reset. No lock counter is synthesized.

## Structure
- **Package `pll_clk_div_pkg`:**
  - constants CNT_W_DEF, DIV_DEFAULT_DEF and LOCK_CYCLES_DEF;
  - typedef `hp_t` (logic [CNT_W_DEF-1:0]).
- **Sub-module `pll_lock_det`:**
  - inputs: clk, clr_n, en, the rise strobe (tick) and an h_q-changed pulse;
  - output: locked.
  - It is instantiated only under `PLL_CLK_DIV_LOCK_EN`.
- **Top level:** contains the counter, the toggle flop, h_q and the tick register.

## Test plan
- **Basic divide.** half_period = 3, en = 1, release reset → clk_out first rises on edge 3, then shows period 6 with 3 high / 3 low. tick is 1 on edges 3, 9, 15.
- **Minimum H.** half_period = 1 → clk_out toggles every cycle. tick is high every 2nd cycle, clk_out stays 50% duty.
- **Default select.** DIV_DEFAULT = 5, half_period = 0 → clk_out period 10, and tick every 10 cycles.
- **Enable stall.** half_period = 3, en = 0 for 4 cycles during a high phase → clk_out stays high 7 cycles total. tick is not repeated, and the counter resumes where it stopped.
- **Live retune.** Change half_period 3 → 2 at cnt = 1 of a high phase → that phase still lasts 3 cycles, and subsequent phases last 2. With the macro defined, locked drops at the retune point and rises again on the 4th new rising edge.
- **Reset mid-run.** clr_n = 0 for 1 cycle while clk_out = 1 → next edge gives clk_out = 0, tick = 0, locked = 0. The first rise comes H cycles after release.
